// File: rtl/regfile_pkg.sv
// Shared constants and the write-qualification predicate for the 2-read/1-write register file.
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_NREGS = 32;
   localparam int ZERO_ADDR = 0;

   // A write only lands if enabled and not aimed at a hardwired-zero register 0.
   function automatic logic write_effective(input logic        we,
                                            input logic [31:0] waddr,
                                            input logic        zero_reg);
      return we && !(zero_reg && (waddr == 32'(ZERO_ADDR)));
   endfunction

endpackage

// File: rtl/mux_nto1.sv
// Generalised NREGS:1 word selector over a flattened storage bus.
module mux_nto1
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREGS = DEF_NREGS,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic [NREGS*WIDTH-1:0] data,
   input  logic [AW-1:0]          sel,
   output logic [WIDTH-1:0]       dout
);

   logic [WIDTH-1:0] words [NREGS];

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
      assign words[gi] = data[gi*WIDTH +: WIDTH];
   end

   assign dout = words[sel];

endmodule

// File: rtl/regfile_2r1w.sv
// NREGS x WIDTH register file with two read ports, one write port, optional
// hardwired zero register, write-to-read bypass and registered reads.
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NREGS    = DEF_NREGS,
   parameter int AW       = $clog2(NREGS),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int READ_REG = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0]       mem_reg [NREGS];
   logic [NREGS*WIDTH-1:0] mem_flat;
   logic                   wr_eff;
   logic [WIDTH-1:0]       mux_a, mux_b;
   logic                   hit_a, hit_b;
   logic                   zero_a, zero_b;
   logic [WIDTH-1:0]       rd_a_next, rd_b_next;

   assign wr_eff = write_effective(we, 32'(waddr), ZERO_REG != 0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem_reg[i] <= '0;
      end else if (wr_eff) begin
         mem_reg[waddr] <= wdata;
      end
   end

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
      assign mem_flat[gi*WIDTH +: WIDTH] = mem_reg[gi];
   end

   mux_nto1 #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_mux_a (
      .data (mem_flat),
      .sel  (raddr_a),
      .dout (mux_a)
   );

   mux_nto1 #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_mux_b (
      .data (mem_flat),
      .sel  (raddr_b),
      .dout (mux_b)
   );

   // Zero is forced on the read side too, so address 0 is defined even before reset.
   assign zero_a = (ZERO_REG != 0) && (raddr_a == AW'(ZERO_ADDR));
   assign zero_b = (ZERO_REG != 0) && (raddr_b == AW'(ZERO_ADDR));
   assign hit_a  = (BYPASS != 0) && wr_eff && (waddr == raddr_a);
   assign hit_b  = (BYPASS != 0) && wr_eff && (waddr == raddr_b);

   assign rd_a_next = zero_a ? '0 : (hit_a ? wdata : mux_a);
   assign rd_b_next = zero_b ? '0 : (hit_b ? wdata : mux_b);

   if (READ_REG != 0) begin : g_rreg
      logic [WIDTH-1:0] rdata_a_reg, rdata_b_reg;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
         end else begin
            rdata_a_reg <= rd_a_next;
            rdata_b_reg <= rd_b_next;
         end
      end

      assign rdata_a = rdata_a_reg;
      assign rdata_b = rdata_b_reg;
   end else begin : g_comb
      assign rdata_a = rd_a_next;
      assign rdata_b = rd_b_next;
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: five register-file configurations driven in lockstep against a reference memory.
module tb_regfile_2r1w;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr_a, raddr_b;

   logic [31:0] a0, b0, a1, b1, a2, b2, a3, b3;
   logic [7:0]  as_, bs_;

   // dut0: bypass, comb read   dut1: no bypass, comb read
   // dut2: bypass, reg read    dut3: no bypass, reg read   dut4: 8x4 bypass, reg read
   regfile_2r1w #(.WIDTH(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(a0), .rdata_b(b0));
   regfile_2r1w #(.WIDTH(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0), .READ_REG(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(a1), .rdata_b(b1));
   regfile_2r1w #(.WIDTH(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1), .READ_REG(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(a2), .rdata_b(b2));
   regfile_2r1w #(.WIDTH(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0), .READ_REG(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(a3), .rdata_b(b3));
   regfile_2r1w #(.WIDTH(8), .NREGS(4), .ZERO_REG(1), .BYPASS(1), .READ_REG(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr[1:0]), .wdata(wdata[7:0]),
      .raddr_a(raddr_a[1:0]), .raddr_b(raddr_b[1:0]), .rdata_a(as_), .rdata_b(bs_));

   typedef struct {
      string       tag;
      int          dut;
      logic [31:0] ea;
      logic [31:0] eb;
   } exp_t;

   exp_t comb_q[$];
   exp_t reg_q[$];

   logic [31:0] mm [32];
   logic [7:0]  ms [4];
   bit          known;
   int          checks;
   int          failures;
   int          txn;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] pred_big(bit byp, logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (byp && we && waddr == a) return wdata;
      return mm[a];
   endfunction

   function automatic logic [31:0] pred_small(logic [1:0] a);
      if (a == 2'd0) return 32'h0;
      if (we && waddr[1:0] == a) return {24'h0, wdata[7:0]};
      return {24'h0, ms[a]};
   endfunction

   function automatic logic [31:0] act_a(int d);
      case (d)
         0: return a0;
         1: return a1;
         2: return a2;
         3: return a3;
         default: return {24'h0, as_};
      endcase
   endfunction

   function automatic logic [31:0] act_b(int d);
      case (d)
         0: return b0;
         1: return b1;
         2: return b2;
         3: return b3;
         default: return {24'h0, bs_};
      endcase
   endfunction

   // One transaction: drive, predict, check combinational ports before the edge, registered after.
   task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input string tag);
      exp_t e;
      @(negedge clk);
      rst_n   = r;
      we      = w;
      waddr   = wa;
      wdata   = wd;
      raddr_a = ra;
      raddr_b = rb;
      txn++;
      if (known) begin
         comb_q.push_back('{tag, 0, pred_big(1'b1, ra), pred_big(1'b1, rb)});
         comb_q.push_back('{tag, 1, pred_big(1'b0, ra), pred_big(1'b0, rb)});
      end
      reg_q.push_back('{tag, 2, r ? pred_big(1'b1, ra) : 32'h0, r ? pred_big(1'b1, rb) : 32'h0});
      reg_q.push_back('{tag, 3, r ? pred_big(1'b0, ra) : 32'h0, r ? pred_big(1'b0, rb) : 32'h0});
      reg_q.push_back('{tag, 4, r ? pred_small(ra[1:0]) : 32'h0, r ? pred_small(rb[1:0]) : 32'h0});
      #2;
      while (comb_q.size() > 0) begin
         e = comb_q.pop_front();
         checks++;
         if (act_a(e.dut) !== e.ea) begin
            failures++;
            $display("FAIL %s dut%0d rdata_a: got %h expected %h", e.tag, e.dut, act_a(e.dut), e.ea);
         end
         checks++;
         if (act_b(e.dut) !== e.eb) begin
            failures++;
            $display("FAIL %s dut%0d rdata_b: got %h expected %h", e.tag, e.dut, act_b(e.dut), e.eb);
         end
      end
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < 32; i++) mm[i] = 32'h0;
         for (int i = 0; i < 4; i++) ms[i] = 8'h0;
         known = 1'b1;
      end else if (w) begin
         if (wa != 5'd0) mm[wa] = wd;
         if (wa[1:0] != 2'd0) ms[wa[1:0]] = wd[7:0];
      end
      #1;
      while (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         checks++;
         if (act_a(e.dut) !== e.ea) begin
            failures++;
            $display("FAIL %s dut%0d rdata_a: got %h expected %h", e.tag, e.dut, act_a(e.dut), e.ea);
         end
         checks++;
         if (act_b(e.dut) !== e.eb) begin
            failures++;
            $display("FAIL %s dut%0d rdata_b: got %h expected %h", e.tag, e.dut, act_b(e.dut), e.eb);
         end
      end
      $display("txn %0d %s rst_n=%0b we=%0b waddr=%0d wdata=%h ra=%0d rb=%0d a0=%h b0=%h a2=%h b2=%h",
               txn, tag, r, w, wa, wd, ra, rb, a0, b0, a2, b2);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd0, "reset");
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, "reset");
      for (int k = 0; k < 32; k++)
         step(1'b1, 1'b0, 5'd0, 32'h0, 5'(k), 5'(k), "reset_read");
   endtask

   task automatic test_write_sweep();
      for (int k = 1; k < 32; k++)
         step(1'b1, 1'b1, 5'(k), 32'hA5A50000 + 32'(k), 5'd0, 5'd0, "write");
      for (int k = 0; k < 32; k++)
         step(1'b1, 1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k), "sweep");
   endtask

   task automatic test_zero_reg();
      step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "zero_wr");
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "zero_rd");
   endtask

   task automatic test_bypass();
      step(1'b1, 1'b1, 5'd5, 32'h11, 5'd0, 5'd0, "bypass_setup");
      step(1'b1, 1'b1, 5'd5, 32'h22, 5'd5, 5'd5, "bypass");
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, "bypass_after");
   endtask

   task automatic test_registered();
      step(1'b1, 1'b1, 5'd7, 32'hDEAD, 5'd0, 5'd0, "rreg_setup");
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7, "rreg_latency");
      step(1'b1, 1'b1, 5'd7, 32'hBEEF, 5'd7, 5'd7, "rreg_bypass");
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "rreg_after");
   endtask

   task automatic test_reset_during_write();
      step(1'b1, 1'b1, 5'd3, 32'h1234, 5'd3, 5'd3, "rstwr_setup");
      step(1'b0, 1'b1, 5'd3, 32'h5678, 5'd1, 5'd2, "rstwr_reset");
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "rstwr_after");
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, "rstwr_after2");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      txn      = 0;
      known    = 1'b0;
      rst_n    = 1'b0;
      we       = 1'b0;
      waddr    = '0;
      wdata    = '0;
      raddr_a  = '0;
      raddr_b  = '0;
      for (int i = 0; i < 32; i++) mm[i] = 32'h0;
      for (int i = 0; i < 4; i++) ms[i] = 8'h0;

      test_reset();
      test_write_sweep();
      test_zero_reg();
      test_bypass();
      test_registered();
      test_reset_during_write();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
